// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer: FSM encoding, default widths and
// register offsets used by both the register block and the counting stage.
package timer_pkg;

  localparam int CNT_W_DEF   = 64;
  localparam int DIV_W_DEF   = 4;
  localparam int DIV_MAX_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } timer_state_e;

  // APB register map, byte offsets
  localparam logic [11:0] TCR_OFS   = 12'h000;
  localparam logic [11:0] TDR0_OFS  = 12'h004;
  localparam logic [11:0] TDR1_OFS  = 12'h008;
  localparam logic [11:0] TCMR0_OFS = 12'h00C;
  localparam logic [11:0] TCMR1_OFS = 12'h010;
  localparam logic [11:0] TIER_OFS  = 12'h014;
  localparam logic [11:0] TISR_OFS  = 12'h018;
  localparam logic [11:0] THCSR_OFS = 12'h01C;

endpackage

// File: rtl/timer_counter_if.sv
// Link between the register block (master) and the counting stage (slave).
// cnt_ovf exists only when TIMER_OVF_FLAG_EN is defined.
interface timer_counter_if
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  // Level-based halt handshake: the master holds halt_req (qualified by
  // dbg_mode) high; the slave answers with halt_ack_status while it is
  // halted and drops it one cycle after the qualified request goes away.
  logic               timer_en;
  logic               div_en;
  logic [DIV_W-1:0]   div_val;
  logic               halt_req;
  logic               dbg_mode;
  logic               counter_clear;
  logic [1:0]         counter_write_sel;
  logic [CNT_W/2-1:0] counter_write_data;
  logic [CNT_W-1:0]   cnt_val;
  logic               halt_ack_status;
  timer_state_e       fsm_state;
`ifdef TIMER_OVF_FLAG_EN
  logic               cnt_ovf;
`endif

  modport master (
    output timer_en, div_en, div_val, halt_req, dbg_mode,
    output counter_clear, counter_write_sel, counter_write_data,
`ifdef TIMER_OVF_FLAG_EN
    input  cnt_ovf,
`endif
    input  cnt_val, halt_ack_status, fsm_state
  );

  modport slave (
    input  timer_en, div_en, div_val, halt_req, dbg_mode,
    input  counter_clear, counter_write_sel, counter_write_data,
`ifdef TIMER_OVF_FLAG_EN
    output cnt_ovf,
`endif
    output cnt_val, halt_ack_status, fsm_state
  );

endinterface

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: tick fires once every 2^div_val cycles while running.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_MAX = DIV_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run,
  input  logic             freeze,
  input  logic             clear,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_MAX-1:0] pcnt;
  logic [DIV_MAX-1:0] limit;
  logic [DIV_W-1:0]   eff_div;

  // Out-of-range exponents are clamped rather than trusted.
  always_comb begin
    eff_div = (div_val > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div_val;
    limit   = '0;
    for (int i = 0; i < DIV_MAX; i++) begin
      limit[i] = (i < int'(eff_div));
    end
    tick = !div_en || (eff_div == '0) || (pcnt == limit);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= tick ? '0 : pcnt + DIV_MAX'(1);
    end else if (!freeze) begin
      pcnt <= '0;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Counting stage of the APB timer: halt FSM, prescaler and 64-bit counter.
// Optional wrap flag cnt_ovf is built when TIMER_OVF_FLAG_EN is defined.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_MAX = DIV_MAX_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  timer_counter_if.slave  bus
);

  localparam int HW = CNT_W / 2;

  timer_state_e     state;
  logic             halt_ack;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             halt_cond;
  logic             run;
  logic             wr_any;

  assign halt_cond = bus.halt_req && bus.dbg_mode;
  assign run       = (state == ST_RUN);
  assign wr_any    = |bus.counter_write_sel;

  // Ack is registered alongside the state so it equals (state == ST_HALT).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      halt_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          halt_ack <= 1'b0;
          if (bus.timer_en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.timer_en) begin
            state    <= ST_IDLE;
            halt_ack <= 1'b0;
          end else if (halt_cond) begin
            state    <= ST_HALT;
            halt_ack <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!bus.timer_en) begin
            state    <= ST_IDLE;
            halt_ack <= 1'b0;
          end else if (!halt_cond) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          halt_ack <= 1'b0;
        end
      endcase
    end
  end

  timer_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run       (run),
    .freeze    (state == ST_HALT),
    .clear     (bus.counter_clear),
    .div_en    (bus.div_en),
    .div_val   (bus.div_val),
    .tick      (tick)
  );

  // Clear beats software write, which beats the tick increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (bus.counter_clear) begin
      cnt <= '0;
    end else if (wr_any) begin
      if (bus.counter_write_sel[0]) cnt[HW-1:0]    <= bus.counter_write_data;
      if (bus.counter_write_sel[1]) cnt[CNT_W-1:HW] <= bus.counter_write_data;
    end else if (run && tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef TIMER_OVF_FLAG_EN
  logic ovf;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf <= 1'b0;
    end else if (bus.counter_clear) begin
      ovf <= 1'b0;
    end else if (!wr_any && run && tick && (&cnt)) begin
      ovf <= 1'b1;
    end
  end

  assign bus.cnt_ovf = ovf;
`endif

  assign bus.cnt_val         = cnt;
  assign bus.halt_ack_status = halt_ack;
  assign bus.fsm_state       = state;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; checks cnt_ovf too when TIMER_OVF_FLAG_EN is set.
module tb_timer_counter;
  import timer_pkg::*;

  logic sys_clk;
  logic sys_rst_n;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  timer_counter_if #(.CNT_W(64), .DIV_W(4)) bus ();

  timer_counter #(.CNT_W(64), .DIV_W(4), .DIV_MAX(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.timer_en           = 1'b0;
    bus.div_en             = 1'b0;
    bus.div_val            = '0;
    bus.halt_req           = 1'b0;
    bus.dbg_mode           = 1'b0;
    bus.counter_clear      = 1'b0;
    bus.counter_write_sel  = 2'b00;
    bus.counter_write_data = '0;
  endtask

  task automatic write_half(input logic [1:0] sel, input logic [31:0] data);
    bus.counter_write_sel  = sel;
    bus.counter_write_data = data;
    step(1);
    bus.counter_write_sel  = 2'b00;
  endtask

  task automatic clear_pulse();
    bus.counter_clear = 1'b1;
    step(1);
    bus.counter_clear = 1'b0;
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef TIMER_OVF_FLAG_EN
    check(tag, {63'd0, bus.cnt_ovf}, {63'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst cnt", bus.cnt_val, 64'd0);
    check("rst ack", {63'd0, bus.halt_ack_status}, 64'd0);
    check("rst state", {62'd0, bus.fsm_state}, {62'd0, ST_IDLE});
    check_ovf("rst ovf", 1'b0);
    step(2);
    sys_rst_n = 1'b1;
    step(1);

    // undivided counting
    bus.timer_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      check("run cnt", bus.cnt_val, 64'(k - 1));
      check("run ack", {63'd0, bus.halt_ack_status}, 64'd0);
    end
    bus.timer_en = 1'b0;
    step(1);
    check("stop edge cnt", bus.cnt_val, 64'd11);
    check("stop state", {62'd0, bus.fsm_state}, {62'd0, ST_IDLE});
    step(1);
    check("stopped hold", bus.cnt_val, 64'd11);
    clear_pulse();
    check("clear cnt", bus.cnt_val, 64'd0);

    // divide by 8: first increment 8 cycles into ST_RUN
    bus.div_en   = 1'b1;
    bus.div_val  = 4'd3;
    bus.timer_en = 1'b1;
    for (int j = 1; j <= 65; j++) exp_q.push_back(64'((j - 1) / 8));
    for (int j = 1; j <= 65; j++) begin
      step(1);
      check("div8 cnt", bus.cnt_val, exp_q.pop_front());
    end
    bus.timer_en = 1'b0;
    step(1);
    clear_pulse();
    check("div8 clear", bus.cnt_val, 64'd0);

    // exponent above DIV_MAX behaves as 2^8
    bus.div_val  = 4'd15;
    bus.timer_en = 1'b1;
    step(256);
    check("clamp before", bus.cnt_val, 64'd0);
    step(1);
    check("clamp tick", bus.cnt_val, 64'd1);
    bus.timer_en = 1'b0;
    step(1);
    clear_pulse();
    bus.div_en  = 1'b0;
    bus.div_val = 4'd0;

    // per-half writes and wrap
    write_half(2'b01, 32'hFFFF_FFFE);
    check("wr low", bus.cnt_val, 64'h0000_0000_FFFF_FFFE);
    write_half(2'b10, 32'hFFFF_FFFF);
    check("wr high", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.timer_en = 1'b1;
    step(1);
    check("wrap enter", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1);
    check("wrap ones", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check_ovf("ovf before", 1'b0);
    step(1);
    check("wrap zero", bus.cnt_val, 64'd0);
    check_ovf("ovf set", 1'b1);
    step(1);
    check("wrap one", bus.cnt_val, 64'd1);

    // debug halt
    bus.halt_req = 1'b1;
    bus.dbg_mode = 1'b1;
    step(1);
    check("halt ack", {63'd0, bus.halt_ack_status}, 64'd1);
    check("halt state", {62'd0, bus.fsm_state}, {62'd0, ST_HALT});
    check("halt cnt", bus.cnt_val, 64'd2);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("halt frozen", bus.cnt_val, 64'd2);
      check("halt ack hold", {63'd0, bus.halt_ack_status}, 64'd1);
    end
    write_half(2'b01, 32'h0000_0100);
    check("halt write", bus.cnt_val, 64'h100);
    step(3);
    check("halt write hold", bus.cnt_val, 64'h100);
    check_ovf("ovf after write", 1'b1);
    bus.dbg_mode = 1'b0;
    step(1);
    check("resume ack", {63'd0, bus.halt_ack_status}, 64'd0);
    check("resume cnt", bus.cnt_val, 64'h100);
    step(1);
    check("resume inc", bus.cnt_val, 64'h101);

    // halt_req without dbg_mode is ignored
    step(5);
    check("nodbg cnt", bus.cnt_val, 64'h106);
    check("nodbg ack", {63'd0, bus.halt_ack_status}, 64'd0);
    bus.halt_req = 1'b0;

    // clear beats write, then stop followed by upstream clear
    bus.counter_clear      = 1'b1;
    bus.counter_write_sel  = 2'b11;
    bus.counter_write_data = 32'h1234;
    step(1);
    check("clr vs wr", bus.cnt_val, 64'd0);
    check_ovf("ovf cleared", 1'b0);
    bus.counter_clear     = 1'b0;
    bus.counter_write_sel = 2'b00;
    step(1);
    check("after clr", bus.cnt_val, 64'd1);
    bus.timer_en = 1'b0;
    step(1);
    check("fall edge", bus.cnt_val, 64'd2);
    step(1);
    check("fall hold", bus.cnt_val, 64'd2);
    clear_pulse();
    check("fall clear", bus.cnt_val, 64'd0);

    // halt request while idle
    bus.halt_req = 1'b1;
    bus.dbg_mode = 1'b1;
    step(3);
    check("idle halt ack", {63'd0, bus.halt_ack_status}, 64'd0);
    check("idle halt state", {62'd0, bus.fsm_state}, {62'd0, ST_IDLE});
    bus.halt_req = 1'b0;
    bus.dbg_mode = 1'b0;

    // asynchronous reset mid-count
    bus.timer_en = 1'b1;
    step(5);
    check("pre reset cnt", bus.cnt_val, 64'd4);
    #3 sys_rst_n = 1'b0;
    #1;
    check("async cnt", bus.cnt_val, 64'd0);
    check("async state", {62'd0, bus.fsm_state}, {62'd0, ST_IDLE});
    bus.timer_en = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    step(1);
    check("post reset cnt", bus.cnt_val, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
